// File: rtl/frame_packer_pkg.sv
// rtl/frame_packer_pkg.sv - shared constants and helpers for the frame packer
// Purpose: frame geometry, CRC-24 generator, FSM state codes, and helpers
//          that pull bytes and the parity field out of the message register.
// Ports:   none (package)
package frame_packer_pkg;

   localparam int FRAME_CHIPS = 224;
   localparam int MSG_BITS    = 112;
   localparam int MSG_BYTES   = 14;
   localparam int CRC_BITS    = 88;
   localparam int CRC_W       = 24;

   localparam logic [CRC_W-1:0] CRC_POLY = 24'hFFF409;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CRC  = 2'd1;
   localparam logic [1:0] S_EMIT = 2'd2;

   // The message register holds bit i of the frame at index i (bit 0 arrives
   // first). A byte is presented MSB-first, so msg[8k] lands in data[7].
   function automatic logic [7:0] msg_byte(input logic [MSG_BITS-1:0] msg,
                                           input logic [3:0] k);
      logic [7:0] b;
      b = '0;
      for (int j = 0; j < 8; j++) begin
         b[7-j] = msg[8*int'(k) + j];
      end
      return b;
   endfunction

   // Parity field (bits 88..111) in the same MSB-first order as the LFSR.
   function automatic logic [CRC_W-1:0] msg_tail(input logic [MSG_BITS-1:0] msg);
      logic [CRC_W-1:0] t;
      t = '0;
      for (int j = 0; j < CRC_W; j++) begin
         t[CRC_W-1-j] = msg[CRC_BITS + j];
      end
      return t;
   endfunction

endpackage

// File: rtl/frame_packer_if.sv
// rtl/frame_packer_if.sv - output byte stream with per-frame status
// Purpose: bundles the byte stream and its frame status sideband.
// Ports:   m_data/m_valid/m_first/m_last/crc_ok/chip_err from the packer,
//          m_ready from the sink. master = packer side, slave = sink side.
interface frame_packer_if;

   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_first;
   logic       m_last;
   logic       crc_ok;
   logic       chip_err;

   modport master (
      output m_data, m_valid, m_first, m_last, crc_ok, chip_err,
      input  m_ready
   );

   modport slave (
      input  m_data, m_valid, m_first, m_last, crc_ok, chip_err,
      output m_ready
   );

endinterface

// File: rtl/frame_packer_crc24.sv
// rtl/frame_packer_crc24.sv - bit-serial CRC-24 remainder register
// Purpose: Galois LFSR, MSB-first, one message bit per enabled cycle.
// Ports:   clk, rst_n (async, active-low), clr (synchronous clear, wins over
//          shift), shift_en, din (next message bit), rem (current remainder),
//          rem_next (remainder after shifting din, lets the caller register a
//          check on the same edge as the final shift).
module crc24_serial
   import frame_packer_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             din,
   output logic [CRC_W-1:0] rem,
   output logic [CRC_W-1:0] rem_next
);

   logic fb;

   always_comb begin
      fb       = din ^ rem[CRC_W-1];
      rem_next = {rem[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem <= '0;
      end else if (clr) begin
         rem <= '0;
      end else if (shift_en) begin
         rem <= rem_next;
      end
   end

endmodule

// File: rtl/frame_packer.sv
// rtl/frame_packer.sv - chip-pair decode, CRC-24 check and 14-byte emit
// Purpose: captures one 224-chip frame per frame_valid strobe while idle,
//          resolves chip pairs to 112 bits, checks CRC-24 over bits 0..87
//          against bits 88..111, then streams the 14 bytes with status.
// Ports:   clk, rst_n (async, active-low), frame_in[223:0], frame_valid,
//          m (frame_packer_if.master: m_data, m_valid, m_ready, m_first,
//          m_last, crc_ok, chip_err), busy, drop_cnt (saturating).
// Config:  FRAME_PACKER_DROP_BAD_EN - frames failing CRC or carrying a chip
//          error are discarded after the check and counted in drop_cnt.
module frame_packer
   import frame_packer_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [FRAME_CHIPS-1:0] frame_in,
   input  logic                   frame_valid,
   frame_packer_if.master         m,
   output logic                   busy,
   output logic [CNT_W-1:0]       drop_cnt
);

   logic [1:0]          state;
   logic [MSG_BITS-1:0] msg;
   logic [MSG_BITS-1:0] dec_bits;
   logic                dec_err;
   logic [6:0]          bit_cnt;
   logic [3:0]          byte_idx;
   logic                crc_ok_r;
   logic                chip_err_r;
   logic [CRC_W-1:0]    rem;
   logic [CRC_W-1:0]    rem_next;
   logic                capture;
   logic                overlap;
   logic                last_shift;
   logic                crc_match;
   logic                frame_bad;
   logic                hs;
   logic                hs_last;
   logic [1:0]          drop_inc;
   logic [CNT_W:0]      drop_sum;

   // "10" -> 1, "01" -> 0; equal chips are invalid and decode as 0.
   always_comb begin
      dec_bits = '0;
      dec_err  = 1'b0;
      for (int i = 0; i < MSG_BITS; i++) begin
         dec_bits[i] = frame_in[FRAME_CHIPS-1-2*i] & ~frame_in[FRAME_CHIPS-2-2*i];
         dec_err     = dec_err | ~(frame_in[FRAME_CHIPS-1-2*i] ^ frame_in[FRAME_CHIPS-2-2*i]);
      end
   end

   assign capture    = (state == S_IDLE) & frame_valid;
   assign overlap    = (state != S_IDLE) & frame_valid;
   assign last_shift = (state == S_CRC) & (bit_cnt == 7'(CRC_BITS-1));
   assign crc_match  = (rem_next == msg_tail(msg));
   assign hs         = m.m_valid & m.m_ready;
   assign hs_last    = hs & (byte_idx == 4'(MSG_BYTES-1));

`ifdef FRAME_PACKER_DROP_BAD_EN
   assign frame_bad = last_shift & (~crc_match | chip_err_r);
`else
   assign frame_bad = 1'b0;
`endif

   crc24_serial #(.POLY(CRC_POLY)) u_crc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (capture),
      .shift_en (state == S_CRC),
      .din      (msg[bit_cnt]),
      .rem      (rem),
      .rem_next (rem_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         msg        <= '0;
         chip_err_r <= 1'b0;
         crc_ok_r   <= 1'b0;
         bit_cnt    <= '0;
         byte_idx   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (frame_valid) begin
                  msg        <= dec_bits;
                  chip_err_r <= dec_err;
                  crc_ok_r   <= 1'b0;
                  bit_cnt    <= '0;
                  byte_idx   <= '0;
                  state      <= S_CRC;
               end
            end
            S_CRC: begin
               bit_cnt <= bit_cnt + 7'd1;
               if (last_shift) begin
                  // rem_next already includes bit 87, so the verdict is
                  // registered on the same edge as the last shift.
                  crc_ok_r <= crc_match;
                  state    <= frame_bad ? S_IDLE : S_EMIT;
               end
            end
            S_EMIT: begin
               if (hs_last) begin
                  byte_idx <= '0;
                  state    <= S_IDLE;
               end else if (hs) begin
                  byte_idx <= byte_idx + 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // An overlap strobe and a bad-frame discard can land on the same edge.
   assign drop_inc = {1'b0, overlap} + {1'b0, frame_bad};
   assign drop_sum = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, drop_inc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (drop_sum[CNT_W]) begin
         drop_cnt <= '1;
      end else begin
         drop_cnt <= drop_sum[CNT_W-1:0];
      end
   end

   // Stream outputs come straight from registers, so they cannot move while
   // the sink stalls; data and markers read zero outside EMIT.
   assign busy       = (state != S_IDLE);
   assign m.m_valid  = (state == S_EMIT);
   assign m.m_data   = m.m_valid ? msg_byte(msg, byte_idx) : 8'h00;
   assign m.m_first  = m.m_valid & (byte_idx == 4'd0);
   assign m.m_last   = m.m_valid & (byte_idx == 4'(MSG_BYTES-1));
   assign m.crc_ok   = crc_ok_r;
   assign m.chip_err = chip_err_r;

endmodule

// File: tb/tb_frame_packer.sv
// tb/tb_frame_packer.sv - scoreboard bench for frame_packer
module tb_frame_packer;
   import frame_packer_pkg::*;

   localparam logic [111:0] F1 = 112'h8D4840D6202CC371C32CE0576098;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [223:0] frame_in = '0;
   logic         frame_valid = 1'b0;
   logic         busy;
   logic [7:0]   drop_cnt;

   frame_packer_if fp_if ();

   frame_packer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .m           (fp_if),
      .busy        (busy),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       f;
      logic       l;
      logic       ok;
      logic       err;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   hs_count = 0;
   int   drops = 0;
   bit   rand_mode = 1'b0;
   bit   ready_force = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference CRC by plain polynomial long division of bits 0..87 * x^24.
   function automatic logic [23:0] ref_crc(input logic [111:0] v);
      logic [111:0] t;
      t = {v[111:24], 24'h0};
      for (int i = 111; i >= 24; i--) begin
         if (t[i]) t[i -: 25] = t[i -: 25] ^ {1'b1, CRC_POLY};
      end
      return t[23:0];
   endfunction

   function automatic logic [223:0] encode(input logic [111:0] v, input int bad_bit,
                                           input logic [1:0] bad_pair);
      logic [223:0] f;
      f = '0;
      for (int i = 0; i < 112; i++) f[223-2*i -: 2] = v[111-i] ? 2'b10 : 2'b01;
      if (bad_bit >= 0) f[223-2*bad_bit -: 2] = bad_pair;
      return f;
   endfunction

   task automatic drop_inc();
      drops = (drops >= 255) ? 255 : drops + 1;
   endtask

   // Expected output for an accepted frame: 14 bytes or, with the discard
   // option, a counted drop for a bad frame.
   task automatic expect_frame(input logic [111:0] v, input int bad_bit);
      logic [111:0] d;
      logic         err;
      logic         ok;
      exp_t         e;
      d   = v;
      err = (bad_bit >= 0);
      if (err) d[111-bad_bit] = 1'b0;
      ok = (ref_crc(d) == d[23:0]);
`ifdef FRAME_PACKER_DROP_BAD_EN
      if (!ok || err) begin
         drop_inc();
         return;
      end
`endif
      for (int k = 0; k < 14; k++) begin
         e.d   = d[111-8*k -: 8];
         e.f   = (k == 0);
         e.l   = (k == 13);
         e.ok  = ok;
         e.err = err;
         q.push_back(e);
      end
   endtask

   task automatic strobe(input logic [223:0] f);
      @(posedge clk); #1;
      frame_in    = f;
      frame_valid = 1'b1;
      @(posedge clk); #1;
      frame_valid = 1'b0;
   endtask

   task automatic wait_drain();
      repeat (95) @(posedge clk);
      for (int i = 0; i < 3000 && q.size() != 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("drain_left", q.size(), 0);
      chk("idle_busy", {31'b0, busy}, 0);
      chk("drop_cnt", {24'b0, drop_cnt}, drops);
   endtask

   task automatic wait_hs(input int target);
      int i;
      for (i = 0; i < 600; i++) begin
         @(negedge clk); #1;
         if (hs_count == target) break;
      end
      chk("hs_wait_timeout", (i < 600) ? 32'd1 : 32'd0, 1);
   endtask

   task automatic send_lat(input logic [111:0] v);
      int n;
      n = -1;
      expect_frame(v, -1);
      strobe(encode(v, -1, 2'b00));
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (fp_if.m_valid) begin
            n = c;
            break;
         end
      end
      chk("latency", n, 88);
   endtask

   // Single driver of m_ready; requests take effect on the next posedge+1.
   initial begin
      fp_if.m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         fp_if.m_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
      end
   end

   exp_t cur;
   exp_t prev;
   bit   stalled = 1'b0;

   always @(negedge clk) begin
      cur = {fp_if.m_data, fp_if.m_first, fp_if.m_last, fp_if.crc_ok, fp_if.chip_err};
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("stall_valid", {31'b0, fp_if.m_valid}, 1);
            chk("stall_hold", {20'b0, cur}, {20'b0, prev});
         end
         if (fp_if.m_valid && fp_if.m_ready) begin
            hs_count++;
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_byte: got %0h expected none", fp_if.m_data);
            end else begin
               chk("byte", {20'b0, cur}, {20'b0, q.pop_front()});
            end
         end
         stalled = fp_if.m_valid && !fp_if.m_ready;
         prev    = cur;
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [111:0] v;
      int           base;
      int           bad;
      logic [1:0]   pair;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'b0, fp_if.m_valid}, 0);
      chk("rst_data", {24'b0, fp_if.m_data}, 0);
      chk("rst_first", {31'b0, fp_if.m_first}, 0);
      chk("rst_last", {31'b0, fp_if.m_last}, 0);
      chk("rst_crc_ok", {31'b0, fp_if.crc_ok}, 0);
      chk("rst_chip_err", {31'b0, fp_if.chip_err}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_drop", {24'b0, drop_cnt}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Known-good frame, latency to first byte.
      send_lat(F1);
      wait_drain();

      // Corrupted parity byte.
      v = F1;
      v[7:0] = 8'h99;
      expect_frame(v, -1);
      strobe(encode(v, -1, 2'b00));
      wait_drain();

      // Invalid chip pairs: "11" on bit 5 (byte 0 -> 89), "00" on bit 100.
      expect_frame(F1, 5);
      strobe(encode(F1, 5, 2'b11));
      wait_drain();
      expect_frame(F1, 100);
      strobe(encode(F1, 100, 2'b00));
      wait_drain();

      // Sink stalls for 10 cycles while byte 3 is presented.
      base = hs_count;
      expect_frame(F1, -1);
      strobe(encode(F1, -1, 2'b00));
      wait_hs(base + 3);
      ready_force = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk("stall_b3_valid", {31'b0, fp_if.m_valid}, 1);
         chk("stall_b3_data", {24'b0, fp_if.m_data}, 32'hD6);
      end
      ready_force = 1'b1;
      wait_drain();

      // Overlapping strobe at cycle 40 (during CRC) is dropped.
      expect_frame(F1, -1);
      strobe(encode(F1, -1, 2'b00));
      repeat (39) @(posedge clk);
      #1;
      frame_in    = encode(~F1, -1, 2'b00);
      frame_valid = 1'b1;
      @(posedge clk); #1;
      frame_valid = 1'b0;
      drop_inc();
      wait_drain();

      // Strobe coinciding with the byte-13 handshake is dropped.
      base = hs_count;
      expect_frame(F1, -1);
      strobe(encode(F1, -1, 2'b00));
      wait_hs(base + 14);
      frame_in    = encode(F1, -1, 2'b00);
      frame_valid = 1'b1;
      @(posedge clk); #1;
      frame_valid = 1'b0;
      drop_inc();
      wait_drain();

      // Randomized frames and sink backpressure.
      rand_mode = 1'b1;
      for (int n = 0; n < 16; n++) begin
         v = {32'($urandom), 32'($urandom), 32'($urandom), 16'($urandom)};
         if ($urandom_range(0, 1) != 0) v[23:0] = ref_crc(v);
         bad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 111)) : -1;
         pair = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
         expect_frame(v, bad);
         strobe(encode(v, bad, pair));
         wait_drain();
      end
      rand_mode   = 1'b0;
      ready_force = 1'b1;

      // 300 overlapping strobes while stalled in EMIT: counter saturates.
      ready_force = 1'b0;
      expect_frame(F1, -1);
      @(posedge clk); #1;
      frame_in    = encode(F1, -1, 2'b00);
      frame_valid = 1'b1;
      repeat (301) @(posedge clk);
      #1;
      frame_valid = 1'b0;
      for (int i = 0; i < 300; i++) drop_inc();
      chk("drop_sat", {24'b0, drop_cnt}, drops);
      chk("drop_sat_255", {24'b0, drop_cnt}, 255);
      ready_force = 1'b1;
      wait_drain();

      // Asynchronous reset while byte 7 is presented.
      base = hs_count;
      expect_frame(F1, -1);
      strobe(encode(F1, -1, 2'b00));
      wait_hs(base + 7);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'b0, fp_if.m_valid}, 0);
      chk("arst_busy", {31'b0, busy}, 0);
      chk("arst_drop", {24'b0, drop_cnt}, 0);
      chk("arst_data", {24'b0, fp_if.m_data}, 0);
      q.delete();
      drops = 0;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("post_rst_busy", {31'b0, busy}, 0);
      send_lat(F1);
      wait_drain();

      chk("scoreboard_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
